// File: rtl/number_pkg.sv
// rtl/number_pkg.sv - shared state type and playfield constants for the number spawner
package number_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SPAWN = 2'd2
    } state_e;

    localparam int NUM_SLOTS              = 4;
    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int SPAWN_PERIOD           = 90;
    localparam int SPEED_MAG              = 30;
    localparam int LEFT_START             = -31;
    localparam int RIGHT_START            = 639;
    localparam int LEFT_LIMIT             = -32;
    localparam int RIGHT_LIMIT            = 640;
    localparam int LANE_Y_DEFAULT [0:3]   = '{80, 160, 240, 320};
    localparam logic [7:0] LFSR_SEED      = 8'hA5;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advanced by step
module lfsr8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [7:0] value
);
    import number_pkg::*;

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/number_spawn_ctrl.sv
// rtl/number_spawn_ctrl.sv - periodic spawner, catch reporter and despawner for number-mover slots
module number_spawn_ctrl #(
    parameter int NUM_SLOTS    = number_pkg::NUM_SLOTS,
    parameter int SPAWN_PERIOD = number_pkg::SPAWN_PERIOD,
    parameter int SPEED_MAG    = number_pkg::SPEED_MAG,
    parameter int LEFT_START   = number_pkg::LEFT_START,
    parameter int RIGHT_START  = number_pkg::RIGHT_START,
    parameter int LEFT_LIMIT   = number_pkg::LEFT_LIMIT,
    parameter int RIGHT_LIMIT  = number_pkg::RIGHT_LIMIT,
    parameter int LANE_Y [0:3] = number_pkg::LANE_Y_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic                  enable,
    input  logic signed [10:0]    slot_topLeftX [NUM_SLOTS],
    input  logic [NUM_SLOTS-1:0]  slot_collision,
    output logic [NUM_SLOTS-1:0]  slot_load,
    output logic signed [31:0]    slot_x_speed [NUM_SLOTS],
    output logic signed [31:0]    slot_init_x [NUM_SLOTS],
    output logic signed [31:0]    slot_init_y [NUM_SLOTS],
    output logic [NUM_SLOTS-1:0]  slot_active,
    output logic                  caught_pulse,
    output logic [1:0]            caught_slot
);
    import number_pkg::*;

    localparam int CNT_W = $clog2(SPAWN_PERIOD + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                 pending_q, pending_d;
    logic [NUM_SLOTS-1:0] active_q, active_d;
    logic [NUM_SLOTS-1:0] load_q, load_d;
    logic [NUM_SLOTS-1:0] load_dly_q, load_dly_d;
    logic [NUM_SLOTS-1:0] catch_pend_q, catch_pend_d;
    logic signed [31:0]   x_speed_q [NUM_SLOTS];
    logic signed [31:0]   x_speed_d [NUM_SLOTS];
    logic signed [31:0]   init_x_q [NUM_SLOTS];
    logic signed [31:0]   init_x_d [NUM_SLOTS];
    logic signed [31:0]   init_y_q [NUM_SLOTS];
    logic signed [31:0]   init_y_d [NUM_SLOTS];
    logic                 caught_pulse_q, caught_pulse_d;
    logic [1:0]           caught_slot_q, caught_slot_d;

    logic [7:0]           lfsr_value;
    logic [1:0]           spawn_lane;
    logic                 spawn_dir;
    logic                 spawn_found;
    logic                 catch_found;
    logic                 unused_lfsr_bits;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (startOfFrame),
        .value (lfsr_value)
    );

    assign spawn_lane       = lfsr_value[1:0];
    assign spawn_dir        = lfsr_value[2];
    assign unused_lfsr_bits = ^lfsr_value[7:3];

    always_comb begin
        state_d        = state_q;
        frame_cnt_d    = frame_cnt_q;
        pending_d      = pending_q;
        active_d       = active_q;
        load_d         = '0;
        load_dly_d     = load_q;
        catch_pend_d   = catch_pend_q;
        x_speed_d      = x_speed_q;
        init_x_d       = init_x_q;
        init_y_d       = init_y_q;
        caught_pulse_d = 1'b0;
        caught_slot_d  = caught_slot_q;
        spawn_found    = 1'b0;
        catch_found    = 1'b0;

        // Bounds are ignored around a load because the mover still shows its old X.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (active_q[i]) begin
                if (slot_collision[i]) begin
                    active_d[i]     = 1'b0;
                    catch_pend_d[i] = 1'b1;
                end else if (!load_q[i] && !load_dly_q[i] &&
                             ((int'(slot_topLeftX[i]) < LEFT_LIMIT) ||
                              (int'(slot_topLeftX[i]) > RIGHT_LIMIT))) begin
                    active_d[i] = 1'b0;
                end
            end
        end

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!catch_found && catch_pend_d[i]) begin
                catch_found     = 1'b1;
                caught_pulse_d  = 1'b1;
                caught_slot_d   = 2'(i);
                catch_pend_d[i] = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pending_q && !(&active_q)) begin
                    state_d = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                state_d   = ST_RUN;
                pending_d = 1'b0;
                // Selection uses start-of-cycle activity, so a slot freed this cycle waits.
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (!spawn_found && !active_q[i]) begin
                        spawn_found  = 1'b1;
                        load_d[i]    = 1'b1;
                        active_d[i]  = 1'b1;
                        init_x_d[i]  = spawn_dir ? RIGHT_START : LEFT_START;
                        x_speed_d[i] = spawn_dir ? -SPEED_MAG : SPEED_MAG;
                        init_y_d[i]  = LANE_Y[spawn_lane];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && startOfFrame) begin
            if (frame_cnt_q == CNT_W'(SPAWN_PERIOD - 1)) begin
                frame_cnt_d = '0;
                pending_d   = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end

        if (!enable) begin
            state_d        = ST_IDLE;
            frame_cnt_d    = '0;
            pending_d      = 1'b0;
            active_d       = '0;
            load_d         = '0;
            load_dly_d     = '0;
            catch_pend_d   = '0;
            x_speed_d      = '{default: '0};
            init_x_d       = '{default: '0};
            init_y_d       = '{default: '0};
            caught_pulse_d = 1'b0;
            caught_slot_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            frame_cnt_q    <= '0;
            pending_q      <= 1'b0;
            active_q       <= '0;
            load_q         <= '0;
            load_dly_q     <= '0;
            catch_pend_q   <= '0;
            x_speed_q      <= '{default: '0};
            init_x_q       <= '{default: '0};
            init_y_q       <= '{default: '0};
            caught_pulse_q <= 1'b0;
            caught_slot_q  <= '0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            pending_q      <= pending_d;
            active_q       <= active_d;
            load_q         <= load_d;
            load_dly_q     <= load_dly_d;
            catch_pend_q   <= catch_pend_d;
            x_speed_q      <= x_speed_d;
            init_x_q       <= init_x_d;
            init_y_q       <= init_y_d;
            caught_pulse_q <= caught_pulse_d;
            caught_slot_q  <= caught_slot_d;
        end
    end

    assign slot_load    = load_q;
    assign slot_active  = active_q;
    assign slot_x_speed = x_speed_q;
    assign slot_init_x  = init_x_q;
    assign slot_init_y  = init_y_q;
    assign caught_pulse = caught_pulse_q;
    assign caught_slot  = caught_slot_q;

endmodule

// File: tb/tb_number_spawn_ctrl.sv
// tb/tb_number_spawn_ctrl.sv - scoreboard bench for number_spawn_ctrl
module tb_number_spawn_ctrl;
    import number_pkg::*;

    localparam int NS = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 startOfFrame;
    logic                 enable;
    logic signed [10:0]   slot_topLeftX [NS];
    logic [NS-1:0]        slot_collision;
    logic [NS-1:0]        slot_load;
    logic signed [31:0]   slot_x_speed [NS];
    logic signed [31:0]   slot_init_x [NS];
    logic signed [31:0]   slot_init_y [NS];
    logic [NS-1:0]        slot_active;
    logic                 caught_pulse;
    logic [1:0]           caught_slot;

    always #5 clk = ~clk;

    number_spawn_ctrl #(.NUM_SLOTS(NS)) dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .enable         (enable),
        .slot_topLeftX  (slot_topLeftX),
        .slot_collision (slot_collision),
        .slot_load      (slot_load),
        .slot_x_speed   (slot_x_speed),
        .slot_init_x    (slot_init_x),
        .slot_init_y    (slot_init_y),
        .slot_active    (slot_active),
        .caught_pulse   (caught_pulse),
        .caught_slot    (caught_slot)
    );

    typedef struct {
        bit is_load;
        int slot;
        int x;
        int y;
        int speed;
    } exp_t;

    exp_t       sb [$];
    exp_t       mon_e;
    exp_t       e0;
    int         n_checks = 0;
    int         n_pass   = 0;
    bit [7:0]   model_lfsr = 8'hA5;
    int         lane_y [4] = '{80, 160, 240, 320};

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit [7:0] lfsr_step(input bit [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic exp_t mk_load(input int slot, input bit [7:0] v);
        exp_t e;
        e.is_load = 1'b1;
        e.slot    = slot;
        e.x       = v[2] ? 639 : -31;
        e.speed   = v[2] ? -30 : 30;
        e.y       = lane_y[v[1:0]];
        return e;
    endfunction

    function automatic exp_t mk_catch(input int slot);
        exp_t e;
        e.is_load = 1'b0;
        e.slot    = slot;
        e.x       = 0;
        e.y       = 0;
        e.speed   = 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        model_lfsr   = lfsr_step(model_lfsr);
        tick();
        startOfFrame = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_frames(input int n);
        for (int k = 0; k < n; k++) sof();
    endtask

    // Completes a spawn period; the load uses the LFSR value after the final frame step.
    task automatic spawn_period(input int slot);
        run_frames(SPAWN_PERIOD - 1);
        sb.push_back(mk_load(slot, lfsr_step(model_lfsr)));
        sof();
        tick();
        tick();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (caught_pulse) begin
                check("sb_has_catch", longint'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("catch_kind", longint'(mon_e.is_load), 0);
                    check("catch_slot", caught_slot, mon_e.slot);
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (slot_load[i]) begin
                    check("sb_has_load", longint'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        check("load_kind", longint'(mon_e.is_load), 1);
                        check("load_slot", i, mon_e.slot);
                        check("load_init_x", slot_init_x[i], mon_e.x);
                        check("load_init_y", slot_init_y[i], mon_e.y);
                        check("load_speed", slot_x_speed[i], mon_e.speed);
                    end
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        startOfFrame   = 1'b0;
        slot_collision = '0;
        foreach (slot_topLeftX[i]) slot_topLeftX[i] = 11'sd100;

        tick();
        tick();
        check("rst_state", int'(dut.state_q), int'(ST_IDLE));
        check("rst_active", slot_active, 0);
        check("rst_load", slot_load, 0);
        check("rst_caught_pulse", caught_pulse, 0);
        check("rst_caught_slot", caught_slot, 0);
        check("rst_speed0", slot_x_speed[0], 0);
        check("rst_init_x3", slot_init_x[3], 0);
        check("rst_init_y2", slot_init_y[2], 0);
        check("rst_lfsr", dut.u_lfsr.value, 8'hA5);
        reset = 1'b0;

        // First spawn after a full period
        enable = 1'b1;
        tick();
        check("run_state", int'(dut.state_q), int'(ST_RUN));
        spawn_period(0);
        check("first_spawn_active", slot_active, 4'b0001);
        e0 = mk_load(0, model_lfsr);

        // Fill all slots, then a full period with nothing free
        for (int s = 1; s < NS; s++) spawn_period(s);
        check("all_active", slot_active, 4'b1111);
        run_frames(SPAWN_PERIOD);
        check("full_no_load_active", slot_active, 4'b1111);
        check("pending_saturated", dut.pending_q, 1);
        check("slot0_init_x_held", slot_init_x[0], e0.x);
        check("slot0_speed_held", slot_x_speed[0], e0.speed);

        // Catch slot 2; the held request respawns into it
        sb.push_back(mk_catch(2));
        sb.push_back(mk_load(2, model_lfsr));
        slot_collision = 4'b0100;
        tick();
        slot_collision = '0;
        check("catch2_freed", slot_active, 4'b1011);
        tick();
        tick();
        tick();
        tick();
        check("respawn2_active", slot_active, 4'b1111);

        // Off-screen despawn and boundary values
        slot_topLeftX[1] = 11'sd641;
        tick();
        check("despawn1_active", slot_active, 4'b1101);
        check("despawn1_no_catch", caught_pulse, 0);
        slot_topLeftX[1] = 11'sd100;
        slot_topLeftX[3] = 11'sd640;
        tick();
        check("right_limit_kept", slot_active, 4'b1101);
        slot_topLeftX[3] = -11'sd32;
        tick();
        check("left_limit_kept", slot_active, 4'b1101);
        slot_topLeftX[3] = -11'sd33;
        tick();
        check("left_despawn3", slot_active, 4'b0101);
        check("left_despawn3_no_catch", caught_pulse, 0);
        slot_topLeftX[3] = 11'sd100;

        // Respawn slot 3 via a fresh period, then simultaneous catch of 0 and 3
        spawn_period(1);
        spawn_period(3);
        check("refill_active", slot_active, 4'b1111);
        sb.push_back(mk_catch(0));
        sb.push_back(mk_catch(3));
        slot_collision = 4'b1001;
        tick();
        slot_collision = '0;
        check("dual_catch_freed", slot_active, 4'b0110);
        check("dual_catch_first", caught_slot, 0);
        tick();
        check("dual_catch_second", caught_slot, 3);
        check("dual_catch_second_pulse", caught_pulse, 1);
        tick();
        check("dual_catch_done", caught_pulse, 0);

        // Drop enable while in SPAWN
        run_frames(SPAWN_PERIOD - 1);
        startOfFrame = 1'b1;
        model_lfsr   = lfsr_step(model_lfsr);
        tick();
        startOfFrame = 1'b0;
        tick();
        check("in_spawn_state", int'(dut.state_q), int'(ST_SPAWN));
        enable = 1'b0;
        tick();
        check("disable_state", int'(dut.state_q), int'(ST_IDLE));
        check("disable_active", slot_active, 0);
        check("disable_load", slot_load, 0);
        check("disable_speed1", slot_x_speed[1], 0);
        tick();

        // Re-enable: first spawn only after a full period
        enable = 1'b1;
        tick();
        run_frames(SPAWN_PERIOD - 1);
        check("reenable_no_early_spawn", slot_active, 0);
        sb.push_back(mk_load(0, lfsr_step(model_lfsr)));
        sof();
        tick();
        tick();
        check("reenable_spawn_active", slot_active, 4'b0001);

        tick();
        tick();
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/number_spawn_ctrl.md
NUMBER_SPAWN_CTRL -- requirements
Module: number_spawn_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of number-mover slots sequenced.
REQ-002 SHALL have parameter SPAWN_PERIOD, default 90, frames between spawn requests.
REQ-003 SHALL have parameter SPEED_MAG, default 30, X speed magnitude in fixed-point units (x64).
REQ-004 SHALL have parameters LEFT_START = -31, RIGHT_START = 639, LEFT_LIMIT = -32, RIGHT_LIMIT = 640, with X start positions and despawn bounds in pixels.
REQ-005 SHALL have parameter LANE_Y[0:3], default {80, 160, 240, 320}, spawn Y per lane.
REQ-006 Ports SHALL be:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-clock pulse per frame.
- enable  in  1  game running.
- slot_topLeftX[NUM_SLOTS]  in  11 signed  mover X positions.
- slot_collision[NUM_SLOTS]  in  1  player caught the slot.
- slot_load[NUM_SLOTS]  out  1  one-clock re-init pulse to the mover.
- slot_x_speed[NUM_SLOTS]  out  32 signed  speed to the mover.
- slot_init_x / slot_init_y[NUM_SLOTS]  out  32 signed  start position.
- slot_active[NUM_SLOTS]  out  1  slot visible/drawable.
- caught_pulse  out  1  one clock per catch.
- caught_slot  out  2  index of the caught slot.

Function
REQ-007 FSM states SHALL be IDLE, RUN and SPAWN.
REQ-008 IDLE -> RUN when enable=1. Any state -> IDLE when enable=0.
REQ-009 On entry to IDLE, every output register SHALL clear, the frame counter SHALL clear, and pending SHALL clear.
REQ-010 In RUN, frame_cnt SHALL increment on each startOfFrame. When frame_cnt = SPAWN_PERIOD-1 on a startOfFrame, frame_cnt SHALL wrap to 0 and spawn_pending SHALL set.
REQ-011 RUN -> SPAWN when spawn_pending=1 and at least one slot_active is 0 at the start of the cycle.
REQ-012 If all slots are active, spawn_pending SHALL hold, with no extra queued requests (saturates at 1).
REQ-013 SPAWN SHALL last exactly one clock. In that clock:
- select the lowest-index free slot.
- assert its slot_load.
- set its slot_active.
- clear spawn_pending.
- return to RUN.
REQ-014 Spawn parameters SHALL come from 8-bit LFSR bits: lane = lfsr[1:0], dir = lfsr[2].
- dir=0: init_x = LEFT_START, speed = +SPEED_MAG.
- dir=1: init_x = RIGHT_START, speed = -SPEED_MAG.
- init_y = LANE_Y[lane].
REQ-015 The LFSR SHALL use polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5. It SHALL step once per startOfFrame regardless of state and SHALL NOT be reset by enable.
REQ-016 slot_init_x, slot_init_y and slot_x_speed SHALL be registered and SHALL be stable from the slot_load cycle until the next load of that slot.
REQ-017 An active slot with slot_collision=1 SHALL clear slot_active on the next clock and pulse caught_pulse with caught_slot = index.
- If several slots collide together, the lowest index is reported that cycle.
- The others are reported on subsequent cycles, one per clock.
REQ-018 An active slot whose topLeftX < LEFT_LIMIT or > RIGHT_LIMIT SHALL clear slot_active on the next clock, with no caught_pulse.
REQ-019 Despawn checks SHALL be suppressed for a slot during its slot_load cycle and the following cycle.
REQ-020 A slot freed in cycle N SHALL NOT be eligible for spawn before cycle N+1.
- If despawn and SPAWN coincide, the spawn takes a different free slot or waits.
REQ-021 Inputs of inactive slots SHALL be ignored.

Reset
REQ-022 reset SHALL be sampled only on posedge clk, and SHALL take priority over enable and startOfFrame.
REQ-023 On reset: state = IDLE, frame_cnt = 0, spawn_pending = 0, LFSR = 8'hA5, all slot outputs 0, caught_pulse = 0, caught_slot = 0.

Structure
REQ-024 A shared package (number_pkg) SHALL hold:
- the state enum.
- NUM_SLOTS, FIXED_POINT_MULTIPLIER = 64, and the lane/limit constants.
REQ-025 The LFSR SHALL be a sub-module, lfsr8, with clk, reset, step and value ports. All other logic SHALL stay in one module.

Verification
REQ-026 Bench SHALL cover these directed scenarios:
- reset=1 for 2 clocks -> all outputs 0 and state IDLE.
- enable=1, 90 startOfFrame pulses -> exactly one slot_load[0] pulse, slot_active[0]=1, values match LFSR-derived lane/dir.
- all 4 slots active, period elapses -> no load. Then collision[2] -> caught_pulse with caught_slot=2, and slot 2 is loaded on the following RUN->SPAWN.
- slot_topLeftX[1] = 641 while active -> slot_active[1]=0 one clock later, caught_pulse=0.
- collision[0] and collision[3] in the same cycle -> caught_slot=0, then caught_slot=3 on the next clock.
- enable dropped mid-spawn -> next clock IDLE, all slot_active=0. Re-enable -> first spawn after 90 frames.
